// File: rtl/fir_tap_accumulator.sv
// rtl/fir_tap_accumulator.sv - sums NUM_TAPS signed samples per frame behind valid/ready handshakes
// Define FIR_ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module fir_tap_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 17,
  parameter int NUM_TAPS   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_ovf
);

  localparam int CNT_WIDTH = $clog2(NUM_TAPS + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_TAPS - 1);
  localparam int MSB = ACC_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                 state, state_n;
  logic [ACC_WIDTH-1:0]   acc, acc_n;
  logic [CNT_WIDTH-1:0]   tap_cnt, cnt_n;
  logic                   ovf, ovf_n;

  logic [ACC_WIDTH-1:0]   ext;
  logic [ACC_WIDTH-1:0]   sum;
  logic [ACC_WIDTH-1:0]   acc_add;
  logic                   carry;
  logic                   add_ovf;
  logic                   accept;

  assign ext = ACC_WIDTH'($signed(in_data));

  // Explicit ripple-carry chain, carry-in 0.
  always_comb begin
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < ACC_WIDTH; i++) begin
      sum[i] = acc[i] ^ ext[i] ^ carry;
      carry  = (acc[i] & ext[i]) | (carry & (acc[i] ^ ext[i]));
    end
  end

  assign add_ovf = (acc[MSB] == ext[MSB]) && (sum[MSB] != acc[MSB]);

`ifdef FIR_ACC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  // Overflow direction follows the common operand sign.
  assign acc_add = add_ovf ? (acc[MSB] ? ACC_MIN : ACC_MAX) : sum;
`else
  assign acc_add = sum;
`endif

  assign in_ready  = rst_n && (state != HOLD);
  assign out_valid = (state == HOLD);
  assign out_data  = acc;
  assign out_ovf   = ovf;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = tap_cnt;
    ovf_n   = ovf;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_n   = ext;
          cnt_n   = CNT_WIDTH'(1);
          ovf_n   = 1'b0;
          state_n = (NUM_TAPS == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_n = acc_add;
          ovf_n = ovf | add_ovf;
          cnt_n = tap_cnt + CNT_WIDTH'(1);
          if (tap_cnt == LAST_CNT) begin
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // Frame abort outranks any accept or output handshake in the same cycle.
    if (clr) begin
      state_n = IDLE;
      acc_n   = '0;
      cnt_n   = '0;
      ovf_n   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      tap_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      tap_cnt <= cnt_n;
      ovf     <= ovf_n;
    end
  end

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// tb/tb_fir_tap_accumulator.sv - scoreboard bench for fir_tap_accumulator
// Honours FIR_ACC_SATURATE_EN the same way as the design.
module tb_fir_tap_accumulator;

  localparam int DW = 16;
  localparam int AW = 17;
  localparam int NT = 4;
  localparam longint MAXV = (longint'(1) << (AW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (AW - 1));
  localparam longint SPAN = longint'(1) << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [AW-1:0] out_data;
  logic          out_ovf;

  fir_tap_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_TAPS(NT)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int frames_done = 0;

  typedef struct {
    logic [AW-1:0] d;
    logic          o;
  } res_t;
  res_t exp_q[$];

  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_ovf = 1'b0;
  bit     m_pend = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: integer arithmetic with an explicit range test on the true sum.
  function automatic void model_accept(logic [DW-1:0] s);
    longint v = longint'($signed(s));
    longint t;
    if (m_cnt == 0) begin
      m_acc = v;
      m_ovf = 1'b0;
    end else begin
      t = m_acc + v;
      if (t > MAXV || t < MINV) begin
        m_ovf = 1'b1;
`ifdef FIR_ACC_SATURATE_EN
        t = (t > MAXV) ? MAXV : MINV;
`else
        t = (t > MAXV) ? t - SPAN : t + SPAN;
`endif
      end
      m_acc = t;
    end
    m_cnt++;
    if (m_cnt == NT) begin
      exp_q.push_back('{AW'(m_acc), m_ovf});
      m_pend = 1'b1;
      m_cnt  = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      m_cnt  = 0;
      m_pend = 1'b0;
      exp_q.delete();
    end else begin
      chk("in_ready", in_ready, !m_pend);
      chk("out_valid", out_valid, m_pend);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          chk("out_data", out_data, exp_q[0].d);
          chk("out_ovf", out_ovf, exp_q[0].o);
        end
      end
      if (clr) begin
        m_cnt  = 0;
        m_pend = 1'b0;
        exp_q.delete();
      end else begin
        if (m_pend && out_ready) begin
          void'(exp_q.pop_front());
          m_pend = 1'b0;
          frames_done++;
        end else if (in_valid && !m_pend) begin
          model_accept(in_data);
        end
      end
    end
  end

  task automatic drive(logic v, logic [DW-1:0] d, logic r, logic c = 1'b0);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  int lows;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);

    drive(1, DW'(12), 1); drive(1, DW'(15), 1); drive(1, DW'(-3), 1); drive(1, DW'(1), 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 17'd25);
    chk("t1_ovf", out_ovf, 0);
    drive(0, '0, 1);
    chk("t1_idle_valid", out_valid, 0);
    chk("t1_idle_ready", in_ready, 1);

    for (int i = 0; i < 4; i++) drive(1, 16'h7FFF, 0);
    chk("t2_valid", out_valid, 1);
`ifdef FIR_ACC_SATURATE_EN
    chk("t2_data", out_data, 17'h0FFFF);
`else
    chk("t2_data", out_data, 17'h1FFFC);
`endif
    chk("t2_ovf", out_ovf, 1);
    drive(0, '0, 1);

    for (int i = 1; i <= 4; i++) drive(1, DW'(i), 0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_valid", out_valid, 1);
      chk("t3_data", out_data, 17'd10);
      chk("t3_ready", in_ready, 0);
      drive(0, '0, (i == 3));
    end
    chk("t3_done", out_valid, 0);

    drive(1, DW'(5), 0); drive(1, DW'(9), 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t4_valid", out_valid, 0);
    chk("t4_data", out_data, 0);
    chk("t4_ovf", out_ovf, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 5; i <= 8; i++) drive(1, DW'(i), 1);
    chk("t4_sum", out_data, 17'd26);
    drive(0, '0, 1);

    for (int i = 0; i < 3; i++) drive(1, DW'(100), 0);
    drive(1, DW'(7), 0, 1);
    for (int i = 1; i <= 4; i++) drive(1, DW'(-i), 1);
    chk("t5_data", out_data, 17'h1FFF6);
    chk("t5_ovf", out_ovf, 0);
    drive(0, '0, 1);

    lows = 0;
    for (int i = 0; i < 15; i++) begin
      if (!in_ready) lows++;
      drive(1, DW'($urandom), 1);
    end
    chk("t6_gaps", lows, 3);
    drive(0, '0, 1);

    for (int i = 0; i < 3000; i++) begin
      logic [DW-1:0] d;
      case ($urandom_range(0, 3))
        0:       d = 16'h7FFF;
        1:       d = 16'h8000;
        default: d = DW'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) == 1,
            $urandom_range(0, 63) == 0);
    end
    for (int i = 0; i < 4; i++) drive(0, '0, 1);
    chk("frames_done", frames_done > 50, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
